// File: rtl/framebuffer_tile_sequencer_if.sv
// Host/rasterizer/framebuffer handshake bundle for the tile sequencer.
// The master side is whoever plays host, rasterizer and framebuffer together.
interface framebuffer_tile_sequencer_if #(
    parameter int Y_BIT_WIDTH      = 11,
    parameter int TILE_INDEX_WIDTH = 8
);
    logic                        start;
    logic [Y_BIT_WIDTH-1:0]      confYResolution;
    logic [Y_BIT_WIDTH-1:0]      confTileHeight;
    logic                        confCommit;
    logic                        confMemset;
    logic                        busy;
    logic                        frameDone;
    logic [TILE_INDEX_WIDTH-1:0] tileIndex;
    logic [Y_BIT_WIDTH-1:0]      tileYOffset;
    logic [Y_BIT_WIDTH-1:0]      tileYResolution;
    logic                        rastStart;
    logic                        rastDone;
    logic                        fbApply;
    logic                        fbApplied;
    logic                        fbCmdCommit;
    logic                        fbCmdMemset;

    modport master (
        output start, confYResolution, confTileHeight, confCommit, confMemset,
               rastDone, fbApplied,
        input  busy, frameDone, tileIndex, tileYOffset, tileYResolution,
               rastStart, fbApply, fbCmdCommit, fbCmdMemset
    );

    modport slave (
        input  start, confYResolution, confTileHeight, confCommit, confMemset,
               rastDone, fbApplied,
        output busy, frameDone, tileIndex, tileYOffset, tileYResolution,
               rastStart, fbApply, fbCmdCommit, fbCmdMemset
    );
endinterface

// File: rtl/framebuffer_tile_sequencer.sv
// Splits a frame into horizontal stripes and, per stripe, runs the rasterizer
// then optionally commits/clears the framebuffer. All outputs registered.
module framebuffer_tile_sequencer #(
    parameter int Y_BIT_WIDTH      = 11,
    parameter int TILE_INDEX_WIDTH = 8
) (
    input logic clk,
    input logic reset,
    framebuffer_tile_sequencer_if.slave seq
);
    typedef enum logic [2:0] {
        IDLE, RAST_START, RAST_WAIT, FB_SETUP, FB_APPLY, FB_ACK, FB_DONE, NEXT
    } state_t;

    state_t                 state;
    logic [Y_BIT_WIDTH-1:0] yRes;
    logic [Y_BIT_WIDTH-1:0] tileH;
    logic                   doCommit;
    logic                   doMemset;
    logic [Y_BIT_WIDTH:0]   nextOffset;
    logic [Y_BIT_WIDTH-1:0] remaining;

    // One extra bit so an offset past the frame end cannot wrap back into range.
    assign nextOffset = {1'b0, seq.tileYOffset} + {1'b0, tileH};
    assign remaining  = yRes - nextOffset[Y_BIT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            yRes                <= '0;
            tileH               <= '0;
            doCommit            <= 1'b0;
            doMemset            <= 1'b0;
            seq.busy            <= 1'b0;
            seq.frameDone       <= 1'b0;
            seq.rastStart       <= 1'b0;
            seq.fbApply         <= 1'b0;
            seq.fbCmdCommit     <= 1'b0;
            seq.fbCmdMemset     <= 1'b0;
            seq.tileIndex       <= '0;
            seq.tileYOffset     <= '0;
            seq.tileYResolution <= '0;
        end else begin
            seq.frameDone <= 1'b0;
            seq.rastStart <= 1'b0;
            seq.fbApply   <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with frameDone belongs to the old frame.
                    if (seq.start && !seq.frameDone) begin
                        yRes            <= seq.confYResolution;
                        tileH           <= seq.confTileHeight;
                        doCommit        <= seq.confCommit;
                        doMemset        <= seq.confMemset;
                        seq.tileIndex   <= '0;
                        seq.tileYOffset <= '0;
                        if (seq.confYResolution == '0 || seq.confTileHeight == '0) begin
                            seq.frameDone <= 1'b1;
                            seq.busy      <= 1'b0;
                        end else begin
                            seq.busy            <= 1'b1;
                            seq.tileYResolution <= (seq.confTileHeight < seq.confYResolution)
                                                 ? seq.confTileHeight : seq.confYResolution;
                            seq.rastStart       <= 1'b1;
                            state               <= RAST_START;
                        end
                    end
                end
                RAST_START: state <= RAST_WAIT;
                RAST_WAIT: begin
                    if (seq.rastDone) state <= (doCommit || doMemset) ? FB_SETUP : NEXT;
                end
                FB_SETUP: begin
                    seq.fbApply     <= 1'b1;
                    seq.fbCmdCommit <= doCommit;
                    seq.fbCmdMemset <= doMemset;
                    state           <= FB_APPLY;
                end
                FB_APPLY: state <= FB_ACK;
                FB_ACK: begin
                    if (!seq.fbApplied) state <= FB_DONE;
                end
                FB_DONE: begin
                    if (seq.fbApplied) begin
                        seq.fbCmdCommit <= 1'b0;
                        seq.fbCmdMemset <= 1'b0;
                        state           <= NEXT;
                    end
                end
                NEXT: begin
                    if (nextOffset >= {1'b0, yRes}) begin
                        seq.frameDone <= 1'b1;
                        seq.busy      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        seq.tileYOffset     <= nextOffset[Y_BIT_WIDTH-1:0];
                        seq.tileYResolution <= (tileH < remaining) ? tileH : remaining;
                        seq.tileIndex       <= seq.tileIndex + 1'b1;
                        seq.rastStart       <= 1'b1;
                        state               <= RAST_START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_tile_sequencer.sv
// Directed bench: rasterizer and framebuffer responders plus an event logger;
// each scenario task checks logged events against hand-derived values.
module tb_framebuffer_tile_sequencer;
    logic clk;
    logic reset;
    int   nChk = 0;
    int   nFail = 0;
    int   cyc = 0;

    framebuffer_tile_sequencer_if #(.Y_BIT_WIDTH(11), .TILE_INDEX_WIDTH(8)) seq ();

    framebuffer_tile_sequencer #(.Y_BIT_WIDTH(11), .TILE_INDEX_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .seq(seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // responder delays
    int rastDly = 2;
    int fbHi = 1;
    int fbLo = 2;
    int fbPhase = 0;
    int fbViol = 0;

    int rdCyc[$];
    int frCyc[$];
    int rsCyc[$], rsOff[$], rsRes[$], rsIdx[$];
    int faCyc[$], faOff[$], faRes[$], faCom[$], faMem[$];
    int fdCyc[$];
    int busyHi = 0;

    // rasterizer: rastDone rastDly cycles after rastStart
    initial begin
        int cnt;
        cnt = 0;
        seq.rastDone = 1'b0;
        forever begin
            @(negedge clk);
            seq.rastDone = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin seq.rastDone = 1'b1; rdCyc.push_back(cyc); end
            end
            if (seq.rastStart === 1'b1) cnt = rastDly;
        end
    end

    // framebuffer: idle-high for fbHi cycles after apply, then low for fbLo cycles
    initial begin
        int cnt;
        cnt = 0;
        seq.fbApplied = 1'b1;
        forever begin
            @(negedge clk);
            case (fbPhase)
                0: if (seq.fbApply === 1'b1) begin fbPhase = 1; cnt = fbHi; end
                1: begin
                    if (seq.fbApply === 1'b1) fbViol++;
                    if (cnt > 0) cnt--;
                    else begin seq.fbApplied = 1'b0; fbPhase = 2; cnt = fbLo; end
                end
                default: begin
                    if (seq.fbApply === 1'b1) fbViol++;
                    cnt--;
                    if (cnt == 0) begin seq.fbApplied = 1'b1; fbPhase = 0; frCyc.push_back(cyc); end
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (seq.rastStart === 1'b1) begin
            rsCyc.push_back(cyc); rsOff.push_back(int'(seq.tileYOffset));
            rsRes.push_back(int'(seq.tileYResolution)); rsIdx.push_back(int'(seq.tileIndex));
        end
        if (seq.fbApply === 1'b1) begin
            faCyc.push_back(cyc); faOff.push_back(int'(seq.tileYOffset));
            faRes.push_back(int'(seq.tileYResolution));
            faCom.push_back(int'(seq.fbCmdCommit)); faMem.push_back(int'(seq.fbCmdMemset));
        end
        if (seq.frameDone === 1'b1) fdCyc.push_back(cyc);
        if (seq.busy === 1'b1) busyHi++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic run_frame(input int yr, input int tl, input bit cm, input bit ms, output int sc);
        @(negedge clk);
        seq.confYResolution = 11'(yr);
        seq.confTileHeight  = 11'(tl);
        seq.confCommit      = cm;
        seq.confMemset      = ms;
        seq.start           = 1'b1;
        sc                  = cyc;
        @(negedge clk);
        seq.start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (seq.frameDone !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        nChk++;
        if (n >= 2000) begin nFail++; $display("FAIL %s_timeout got no frameDone want frameDone", nm); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        seq.start = 1'b0; seq.confYResolution = '0; seq.confTileHeight = '0;
        seq.confCommit = 1'b0; seq.confMemset = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        nChk++;
        if ({seq.busy, seq.frameDone, seq.rastStart, seq.fbApply, seq.fbCmdCommit, seq.fbCmdMemset} !== 6'b0) begin
            nFail++; $display("FAIL rst_flags got %b want 000000",
                {seq.busy, seq.frameDone, seq.rastStart, seq.fbApply, seq.fbCmdCommit, seq.fbCmdMemset});
        end
        nChk++; if (seq.tileIndex !== 8'd0) begin nFail++; $display("FAIL rst_idx got %0d want 0", seq.tileIndex); end
        nChk++; if (seq.tileYOffset !== 11'd0) begin nFail++; $display("FAIL rst_off got %0d want 0", seq.tileYOffset); end
        nChk++; if (seq.tileYResolution !== 11'd0) begin nFail++; $display("FAIL rst_res got %0d want 0", seq.tileYResolution); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_commit_memset();
        int sc, b, f, d, r, q;
        int eOff[3] = '{0, 4, 8};
        int eRes[3] = '{4, 4, 2};
        b = rsCyc.size(); f = faCyc.size(); d = fdCyc.size(); r = rdCyc.size(); q = frCyc.size();
        run_frame(10, 4, 1'b1, 1'b1, sc);
        wait_done("cm");
        nChk++; if (rsCyc.size() - b != 3) begin nFail++; $display("FAIL cm_rs_count got %0d want 3", rsCyc.size() - b); end
        nChk++; if (faCyc.size() - f != 3) begin nFail++; $display("FAIL cm_fa_count got %0d want 3", faCyc.size() - f); end
        nChk++; if (fdCyc.size() - d != 1) begin nFail++; $display("FAIL cm_fd_count got %0d want 1", fdCyc.size() - d); end
        if (rsCyc.size() - b == 3 && faCyc.size() - f == 3 && rdCyc.size() - r >= 3 && frCyc.size() - q >= 3) begin
            nChk++; if (rsCyc[b] != sc + 1) begin nFail++; $display("FAIL cm_first_rs got %0d want %0d", rsCyc[b], sc + 1); end
            for (int i = 0; i < 3; i++) begin
                nChk++; if (rsOff[b+i] != eOff[i]) begin nFail++; $display("FAIL cm_off[%0d] got %0d want %0d", i, rsOff[b+i], eOff[i]); end
                nChk++; if (rsRes[b+i] != eRes[i]) begin nFail++; $display("FAIL cm_res[%0d] got %0d want %0d", i, rsRes[b+i], eRes[i]); end
                nChk++; if (rsIdx[b+i] != i) begin nFail++; $display("FAIL cm_idx[%0d] got %0d want %0d", i, rsIdx[b+i], i); end
                nChk++; if (faOff[f+i] != eOff[i] || faRes[f+i] != eRes[i]) begin
                    nFail++; $display("FAIL cm_fa_geom[%0d] got %0d/%0d want %0d/%0d", i, faOff[f+i], faRes[f+i], eOff[i], eRes[i]);
                end
                nChk++; if (faCom[f+i] != 1 || faMem[f+i] != 1) begin
                    nFail++; $display("FAIL cm_cmd[%0d] got %0d%0d want 11", i, faCom[f+i], faMem[f+i]);
                end
                nChk++; if (faCyc[f+i] != rdCyc[r+i] + 2) begin
                    nFail++; $display("FAIL cm_apply_lat[%0d] got %0d want %0d", i, faCyc[f+i], rdCyc[r+i] + 2);
                end
            end
            nChk++; if (rsCyc[b+1] != frCyc[q] + 2) begin nFail++; $display("FAIL cm_next_rs got %0d want %0d", rsCyc[b+1], frCyc[q] + 2); end
            nChk++; if (fdCyc[d] != frCyc[q+2] + 2) begin nFail++; $display("FAIL cm_fd_lat got %0d want %0d", fdCyc[d], frCyc[q+2] + 2); end
        end
        nChk++; if (seq.busy !== 1'b0) begin nFail++; $display("FAIL cm_busy_end got %b want 0", seq.busy); end
    endtask

    task automatic test_no_fb();
        int sc, b, f, d, r;
        b = rsCyc.size(); f = faCyc.size(); d = fdCyc.size(); r = rdCyc.size();
        run_frame(8, 4, 1'b0, 1'b0, sc);
        wait_done("nofb");
        nChk++; if (rsCyc.size() - b != 2) begin nFail++; $display("FAIL nofb_rs_count got %0d want 2", rsCyc.size() - b); end
        nChk++; if (faCyc.size() - f != 0) begin nFail++; $display("FAIL nofb_fa_count got %0d want 0", faCyc.size() - f); end
        if (rsCyc.size() - b == 2 && rdCyc.size() - r >= 2 && fdCyc.size() - d == 1) begin
            nChk++; if (rsOff[b+1] != 4 || rsRes[b+1] != 4) begin nFail++; $display("FAIL nofb_geom got %0d/%0d want 4/4", rsOff[b+1], rsRes[b+1]); end
            nChk++; if (rsCyc[b+1] != rdCyc[r] + 2) begin nFail++; $display("FAIL nofb_rs_lat got %0d want %0d", rsCyc[b+1], rdCyc[r] + 2); end
            nChk++; if (fdCyc[d] != rdCyc[r+1] + 2) begin nFail++; $display("FAIL nofb_fd_lat got %0d want %0d", fdCyc[d], rdCyc[r+1] + 2); end
        end
    endtask

    task automatic test_zero();
        int sc, b, d, bh;
        int yrV[2] = '{0, 5};
        int tlV[2] = '{4, 0};
        for (int k = 0; k < 2; k++) begin
            b = rsCyc.size(); d = fdCyc.size(); bh = busyHi;
            run_frame(yrV[k], tlV[k], 1'b1, 1'b1, sc);
            wait_done("zero");
            nChk++; if (fdCyc.size() - d != 1) begin nFail++; $display("FAIL zero%0d_fd_count got %0d want 1", k, fdCyc.size() - d); end
            if (fdCyc.size() - d == 1) begin
                nChk++; if (fdCyc[d] != sc + 1) begin nFail++; $display("FAIL zero%0d_fd_cyc got %0d want %0d", k, fdCyc[d], sc + 1); end
            end
            nChk++; if (rsCyc.size() != b) begin nFail++; $display("FAIL zero%0d_rs got %0d want 0", k, rsCyc.size() - b); end
            nChk++; if (busyHi != bh) begin nFail++; $display("FAIL zero%0d_busy got %0d want 0", k, busyHi - bh); end
        end
    endtask

    task automatic test_slow_fb();
        int sc, b, f, d, q, v;
        fbHi = 3; fbLo = 20;
        b = rsCyc.size(); f = faCyc.size(); d = fdCyc.size(); q = frCyc.size(); v = fbViol;
        run_frame(8, 4, 1'b1, 1'b0, sc);
        wait_done("slow");
        nChk++; if (faCyc.size() - f != 2) begin nFail++; $display("FAIL slow_fa_count got %0d want 2", faCyc.size() - f); end
        nChk++; if (fbViol != v) begin nFail++; $display("FAIL slow_double_apply got %0d want 0", fbViol - v); end
        if (rsCyc.size() - b == 2 && frCyc.size() - q >= 2 && fdCyc.size() - d == 1 && faCyc.size() - f == 2) begin
            nChk++; if (rsCyc[b+1] != frCyc[q] + 2) begin nFail++; $display("FAIL slow_rs_lat got %0d want %0d", rsCyc[b+1], frCyc[q] + 2); end
            nChk++; if (fdCyc[d] != frCyc[q+1] + 2) begin nFail++; $display("FAIL slow_fd_lat got %0d want %0d", fdCyc[d], frCyc[q+1] + 2); end
            nChk++; if (faCom[f] != 1 || faMem[f] != 0) begin nFail++; $display("FAIL slow_cmd got %0d%0d want 10", faCom[f], faMem[f]); end
        end
        fbHi = 1; fbLo = 2;
    endtask

    task automatic test_busy_ignore();
        int sc, b, f, d;
        int eOff[3] = '{0, 4, 8};
        int eRes[3] = '{4, 4, 2};
        b = rsCyc.size(); f = faCyc.size(); d = fdCyc.size();
        run_frame(10, 4, 1'b0, 1'b1, sc);
        repeat (3) @(negedge clk);
        seq.confYResolution = 11'd2; seq.confTileHeight = 11'd1;
        seq.confCommit = 1'b1; seq.confMemset = 1'b0; seq.start = 1'b1;
        @(negedge clk);
        seq.start = 1'b0;
        wait_done("ign");
        nChk++; if (rsCyc.size() - b != 3) begin nFail++; $display("FAIL ign_rs_count got %0d want 3", rsCyc.size() - b); end
        nChk++; if (fdCyc.size() - d != 1) begin nFail++; $display("FAIL ign_fd_count got %0d want 1", fdCyc.size() - d); end
        if (rsCyc.size() - b == 3 && faCyc.size() - f == 3) begin
            for (int i = 0; i < 3; i++) begin
                nChk++; if (rsOff[b+i] != eOff[i] || rsRes[b+i] != eRes[i]) begin
                    nFail++; $display("FAIL ign_geom[%0d] got %0d/%0d want %0d/%0d", i, rsOff[b+i], rsRes[b+i], eOff[i], eRes[i]);
                end
                nChk++; if (faCom[f+i] != 0 || faMem[f+i] != 1) begin
                    nFail++; $display("FAIL ign_cmd[%0d] got %0d%0d want 01", i, faCom[f+i], faMem[f+i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int sc, n, b;
        run_frame(4, 4, 1'b0, 1'b0, sc);
        n = 0;
        while (seq.frameDone !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        nChk++; if (n >= 2000) begin nFail++; $display("FAIL b2b_timeout got no frameDone want frameDone"); end
        // start during the frameDone cycle must be dropped
        seq.confYResolution = 11'd4; seq.confTileHeight = 11'd2; seq.start = 1'b1;
        @(negedge clk);
        nChk++; if (seq.busy !== 1'b0 || seq.rastStart !== 1'b0) begin
            nFail++; $display("FAIL b2b_ignored got busy=%b rs=%b want 0/0", seq.busy, seq.rastStart);
        end
        b = rsCyc.size();
        @(negedge clk);
        seq.start = 1'b0;
        nChk++; if (seq.busy !== 1'b1 || seq.rastStart !== 1'b1 || seq.tileYResolution !== 11'd2) begin
            nFail++; $display("FAIL b2b_accept got busy=%b rs=%b res=%0d want 1/1/2", seq.busy, seq.rastStart, seq.tileYResolution);
        end
        wait_done("b2b");
        nChk++; if (rsCyc.size() - b != 2) begin nFail++; $display("FAIL b2b_rs_count got %0d want 2", rsCyc.size() - b); end
    endtask

    task automatic test_reset_mid();
        int sc, n, b, f, d;
        fbLo = 8;
        run_frame(8, 4, 1'b1, 1'b0, sc);
        n = 0;
        while (seq.fbApply !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        nChk++; if (n >= 2000) begin nFail++; $display("FAIL rmid_timeout got no fbApply want fbApply"); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        b = rsCyc.size(); f = faCyc.size(); d = fdCyc.size();
        nChk++;
        if ({seq.busy, seq.frameDone, seq.rastStart, seq.fbApply, seq.fbCmdCommit, seq.fbCmdMemset} !== 6'b0 ||
            seq.tileIndex !== 8'd0 || seq.tileYOffset !== 11'd0 || seq.tileYResolution !== 11'd0) begin
            nFail++; $display("FAIL rmid_outputs got busy=%b cmd=%b%b off=%0d res=%0d want all zero",
                seq.busy, seq.fbCmdCommit, seq.fbCmdMemset, seq.tileYOffset, seq.tileYResolution);
        end
        repeat (12) @(negedge clk);
        nChk++; if (rsCyc.size() != b || faCyc.size() != f || fdCyc.size() != d) begin
            nFail++; $display("FAIL rmid_no_pulse got %0d/%0d/%0d want 0/0/0", rsCyc.size() - b, faCyc.size() - f, fdCyc.size() - d);
        end
        fbLo = 2;
        b = rsCyc.size(); d = fdCyc.size();
        run_frame(8, 4, 1'b1, 1'b0, sc);
        wait_done("rmid");
        nChk++; if (rsCyc.size() - b != 2 || fdCyc.size() - d != 1) begin
            nFail++; $display("FAIL rmid_rerun got %0d stripes %0d done want 2/1", rsCyc.size() - b, fdCyc.size() - d);
        end
        if (rsCyc.size() - b == 2) begin
            nChk++; if (rsOff[b] != 0 || rsOff[b+1] != 4) begin nFail++; $display("FAIL rmid_offsets got %0d,%0d want 0,4", rsOff[b], rsOff[b+1]); end
        end
    endtask

    initial begin
        test_reset();
        test_commit_memset();
        test_no_fb();
        test_zero();
        test_slow_fb();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nFail);
        $finish;
    end
endmodule
